// File: rtl/regs_wb_ctrl_pkg.sv
// Shared types and constants for the register-file write-back controller.
// Holds the FSM state encoding and the default geometry of the register file.
// Imported by the interface, the hold-entry sub-module and the top.
package regs_wb_ctrl_pkg;

    localparam int XLEN_WIDTH   = 32;
    localparam int REG_COUNT    = 32;
    localparam int REG_ADDR_W   = $clog2(REG_COUNT);
    localparam int STARVE_LIMIT = 4;

    typedef enum logic {
        WB_INIT = 1'b0,
        WB_RUN  = 1'b1
    } wb_state_e;

endpackage

// File: rtl/regs_wb_ctrl_if.sv
// Bundle of the write-back sources, register-file write port and hazard lookup.
// Latency: n/a (wires only).
// Backpressure: ex/mem use valid/ready; write port has no backpressure.
// Ports: ex_* / mem_* result sources, write_* register-file port,
//        rd_addr*/hazard* decode lookup, init_done sweep status.
interface regs_wb_ctrl_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            ex_valid;
    logic            ex_ready;
    logic [AW-1:0]   ex_addr;
    logic [XLEN-1:0] ex_data;
    logic            mem_valid;
    logic            mem_ready;
    logic [AW-1:0]   mem_addr;
    logic [XLEN-1:0] mem_data;
    logic            write_en;
    logic [AW-1:0]   write_addr;
    logic [XLEN-1:0] write_data;
    logic [AW-1:0]   rd_addr1;
    logic [AW-1:0]   rd_addr2;
    logic            hazard1;
    logic            hazard2;
    logic            init_done;

    // Pipeline side: produces results and read addresses.
    modport master (
        output ex_valid, ex_addr, ex_data, mem_valid, mem_addr, mem_data,
               rd_addr1, rd_addr2,
        input  ex_ready, mem_ready, write_en, write_addr, write_data,
               hazard1, hazard2, init_done
    );

    // Controller side.
    modport slave (
        input  ex_valid, ex_addr, ex_data, mem_valid, mem_addr, mem_data,
               rd_addr1, rd_addr2,
        output ex_ready, mem_ready, write_en, write_addr, write_data,
               hazard1, hazard2, init_done
    );
endinterface

// File: rtl/regs_wb_ctrl_hold_entry.sv
// Single-entry buffer for a mem result that lost the write port.
// Latency: loaded entry visible the cycle after load.
// Backpressure: none itself; the top refuses mem while the entry is full and not draining.
// Ports: flush/load/pop controls, ex write snoop (ex_wr_i/ex_addr_i), entry contents, starved flag.
module wb_hold_entry #(
    parameter int XLEN         = 32,
    parameter int AW           = 5,
    parameter int STARVE_LIMIT = 4,
    parameter int CW           = $clog2(STARVE_LIMIT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            load_i,
    input  logic [AW-1:0]   load_addr_i,
    input  logic [XLEN-1:0] load_data_i,
    input  logic            pop_i,
    input  logic            ex_wr_i,
    input  logic [AW-1:0]   ex_addr_i,
    output logic            vld_o,
    output logic [AW-1:0]   addr_o,
    output logic [XLEN-1:0] data_o,
    output logic            starved_o
);
    logic            vld_q,  vld_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [CW-1:0]   cnt_q,  cnt_d;
    logic            hit;

    // A younger ex write to our register makes the held value stale.
    assign hit = vld_q && ex_wr_i && (ex_addr_i == addr_q) && (addr_q != '0);

    always_comb begin
        vld_d  = vld_q;
        addr_d = addr_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            vld_d = 1'b0;
            cnt_d = '0;
        end else begin
            if (pop_i || hit) begin
                vld_d = 1'b0;
                cnt_d = '0;
            end else if (vld_q && ex_wr_i && (cnt_q != CW'(STARVE_LIMIT))) begin
                cnt_d = cnt_q + CW'(1);
            end
            // A load only happens into an empty or draining entry.
            if (load_i) begin
                vld_d  = 1'b1;
                addr_d = load_addr_i;
                data_d = load_data_i;
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign vld_o     = vld_q;
    assign addr_o    = addr_q;
    assign data_o    = data_q;
    assign starved_o = vld_q && (cnt_q == CW'(STARVE_LIMIT));
endmodule

// File: rtl/regs_wb_ctrl.sv
// Write-back controller: zero-sweeps the register file, then arbitrates ex/mem onto one write port.
// Latency: accepted result appears on write_* one edge later; held mem results at least two.
// Backpressure: ex refused only when the hold entry is starved or during sweep/clear; mem refused while hold is full and not draining.
// Ports: clk, rst (async active-low), clr (soft clear), bus (slave side of regs_wb_ctrl_if).
module regs_wb_ctrl
    import regs_wb_ctrl_pkg::*;
#(
    parameter int XLEN         = XLEN_WIDTH,
    parameter int REG_COUNT    = regs_wb_ctrl_pkg::REG_COUNT,
    parameter int STARVE_LIMIT = regs_wb_ctrl_pkg::STARVE_LIMIT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    regs_wb_ctrl_if.slave bus
);
    localparam int AW = $clog2(REG_COUNT);

    wb_state_e       state_q, state_d;
    logic [AW-1:0]   sweep_q, sweep_d;
    logic            write_en_q, write_en_d;
    logic [AW-1:0]   write_addr_q, write_addr_d;
    logic [XLEN-1:0] write_data_q, write_data_d;

    logic            hold_vld, hold_starved;
    logic [AW-1:0]   hold_addr;
    logic [XLEN-1:0] hold_data;

    logic act, ex_rdy, mem_rdy, hold_wr, mem_direct, mem_drop, mem_load;

    // Handshakes only happen in RUN and never in a clear cycle.
    assign act     = (state_q == WB_RUN) && !clr;
    assign ex_rdy  = act && bus.ex_valid && !hold_starved;
    assign hold_wr = act && hold_vld && (hold_starved || !bus.ex_valid);
    assign mem_rdy = act && bus.mem_valid && (!hold_vld || hold_wr);
    // Same-cycle ex to the same register is younger: the mem result is discarded.
    assign mem_drop   = mem_rdy && ex_rdy && (bus.mem_addr == bus.ex_addr) && (bus.ex_addr != '0);
    assign mem_direct = mem_rdy && !hold_vld && !bus.ex_valid;
    assign mem_load   = mem_rdy && !mem_direct && !mem_drop;

    wb_hold_entry #(
        .XLEN(XLEN), .AW(AW), .STARVE_LIMIT(STARVE_LIMIT)
    ) u_hold (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (clr),
        .load_i      (mem_load),
        .load_addr_i (bus.mem_addr),
        .load_data_i (bus.mem_data),
        .pop_i       (hold_wr),
        .ex_wr_i     (ex_rdy),
        .ex_addr_i   (bus.ex_addr),
        .vld_o       (hold_vld),
        .addr_o      (hold_addr),
        .data_o      (hold_data),
        .starved_o   (hold_starved)
    );

    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        write_en_d   = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        case (state_q)
            WB_INIT: begin
                if (clr) begin
                    sweep_d = AW'(1);
                end else if (sweep_q == '0) begin
                    // Counter wrapped past the last register: sweep finished.
                    state_d = WB_RUN;
                end else begin
                    write_en_d   = 1'b1;
                    write_addr_d = sweep_q;
                    write_data_d = '0;
                    sweep_d      = (sweep_q == AW'(REG_COUNT - 1)) ? '0 : sweep_q + AW'(1);
                end
            end
            default: begin
                if (clr) begin
                    state_d = WB_INIT;
                    sweep_d = AW'(1);
                end else if (hold_wr) begin
                    write_en_d   = (hold_addr != '0);
                    write_addr_d = hold_addr;
                    write_data_d = hold_data;
                end else if (ex_rdy) begin
                    write_en_d   = (bus.ex_addr != '0);
                    write_addr_d = bus.ex_addr;
                    write_data_d = bus.ex_data;
                end else if (mem_direct) begin
                    write_en_d   = (bus.mem_addr != '0);
                    write_addr_d = bus.mem_addr;
                    write_data_d = bus.mem_data;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= WB_INIT;
            sweep_q      <= AW'(1);
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
        end
    end

    assign bus.ex_ready   = ex_rdy;
    assign bus.mem_ready  = mem_rdy;
    assign bus.write_en   = write_en_q;
    assign bus.write_addr = write_addr_q;
    assign bus.write_data = write_data_q;
    assign bus.init_done  = (state_q == WB_RUN);
    assign bus.hazard1    = hold_vld && (hold_addr != '0) && (bus.rd_addr1 == hold_addr);
    assign bus.hazard2    = hold_vld && (hold_addr != '0) && (bus.rd_addr2 == hold_addr);
endmodule

// File: doc/regs_wb_ctrl.md
# regs_wb_ctrl

Write-back controller for the integer register file. It shares the file's single write port between the execute-stage and memory-stage result paths. After reset it sweeps every architectural register to zero, because the register file resets only x0. Sits between the pipeline write-back sources and the register file's `write_en/write_addr/write_data` port.

## Interface
Parameters:
- `XLEN` = 32: data width; matches `` `XLEN_WIDTH ``.
- `REG_COUNT` = 32: number of architectural registers; matches `` `REG_COUNT ``.
- `STARVE_LIMIT` = 4: consecutive cycles the hold entry may lose arbitration before it is forced through.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous soft clear; restarts the zero sweep.
- `ex_valid` in 1: execute-stage result valid.
- `ex_ready` out 1: execute-stage result accepted this cycle.
- `ex_addr` in `` `REG_ADDR ``: destination register of the execute-stage result.
- `ex_data` in XLEN: execute-stage result data.
- `mem_valid` in 1: memory-stage result valid.
- `mem_ready` out 1: memory-stage result accepted this cycle.
- `mem_addr` in `` `REG_ADDR ``: destination register of the memory-stage result.
- `mem_data` in XLEN: memory-stage result data.
- `write_en` out 1: registered write strobe to the register file.
- `write_addr` out `` `REG_ADDR ``: registered write address.
- `write_data` out XLEN: registered write data.
- `rd_addr1`, `rd_addr2` in `` `REG_ADDR ``: decode-stage read addresses.
- `hazard1`, `hazard2` out 1: the read address matches the valid hold entry (nonzero address).
- `init_done` out 1: zero sweep complete; high in RUN.

## Operation
- States: INIT, RUN.
- Reset enters INIT with the sweep counter at 1.
- INIT:
  - Each cycle, issue a write of 0 to the sweep counter address, then increment the counter.
  - After the write to `REG_COUNT-1`, go to RUN.
  - `ex_ready` and `mem_ready` are 0 throughout.
- RUN: at most one write is issued per cycle, chosen in this priority order:
  - Forced hold: the hold entry is valid and the starve counter equals `STARVE_LIMIT`. The hold entry is written and `ex_ready`=0.
  - `ex_valid`: the ex result is written and `ex_ready`=1.
  - Hold entry valid: the hold entry is written.
  - `mem_valid` with the hold entry empty: the mem result is written directly.
- `mem_ready`=1 when either:
  - the hold entry is empty, or
  - the hold entry is written this cycle.
  
  A mem result accepted but not written this cycle is loaded into the hold entry.
- Supersede rules, applied only when the addresses are equal and nonzero:
  - An ex write to the same address as the hold entry invalidates the hold entry (ex is the younger result).
  - If an incoming mem result matches the ex address in the same cycle, it is accepted and dropped.
- Address 0: the handshake completes normally, but `write_en` stays 0.
- Starve counter:
  - Increments each cycle the hold entry is valid and loses to ex.
  - Clears when the hold entry is written or invalidated.
  - Saturates at `STARVE_LIMIT`.
- `clr` in RUN:
  - Invalidates the hold entry.
  - Clears the starve counter.
  - Sets the sweep counter to 1 and enters INIT on the next edge.
  - Handshakes that cycle are refused (`ex_ready`=`mem_ready`=0).
- `clr` in INIT restarts the sweep at 1.
- The hazard outputs are combinational from `rd_addr*` and the hold entry. The write-port register is covered by the register file's bypass.

## Timing
- Reset values:
  - `write_en`=0, `write_addr`=0, `write_data`=0.
  - `init_done`=0, `ex_ready`=0, `mem_ready`=0, `hazard1`=`hazard2`=0.
  - Hold entry invalid; starve counter 0.
- The first sweep write appears on `write_en` after the first rising edge following reset release. The sweep then issues writes on `REG_COUNT-1` consecutive cycles.
- `init_done` rises on the edge after the last sweep write is registered.
- Latency: a source accepted at edge N appears on `write_*` after edge N. A held mem entry appears no earlier than edge N+1.
- `ex_ready`/`mem_ready` are combinational from the valids, the state, the hold entry and the starve counter. They never depend on the other source's ready.
- Asserting reset mid-sweep or mid-RUN clears everything immediately; accepted-but-unwritten hold data is lost.

## Structure
- Add a state encoding (`WB_INIT`, `WB_RUN`) and the default `STARVE_LIMIT` to `define/const.v`.
- Reuse `` `REG_ADDR ``, `` `XLEN_WIDTH ``, `` `REG_COUNT `` from the same file.
- One sub-module, `wb_hold_entry`: a single-entry buffer with valid, address, data, starve counter, and invalidate-on-match logic. Arbitration and the FSM stay in the top module.

## Test plan
- Reset, then release: 31 writes of 0 to addresses 1..31 on consecutive cycles, then `init_done`=1; `ex_ready`=0 until then.
- RUN, ex(5,0xA) and mem(6,0xB) in the same cycle:
  - next cycle, `write_*` shows (5,0xA) and the hold entry holds (6,0xB);
  - `hazard1`=1 for `rd_addr1`=6;
  - with ex idle, (6,0xB) is written the following cycle.
- Same-address case, ex(7,0x1) and mem(7,0x2) simultaneously: only (7,0x1) is written; both readies are 1; the hold entry stays empty.
- Starvation: hold entry (9,0xC) while ex_valid is held high continuously. After 4 ex wins, `ex_ready`=0 for one cycle and (9,0xC) is written.
- ex to address 0 with `ex_valid`=1: `ex_ready`=1 and `write_en` stays 0.
- `clr` while the hold entry holds (3,0xD): the entry is dropped, the sweep restarts at address 1, and (3,0xD) is never written.
